// File: rtl/ucode_issue_arbiter.sv
// Decode-slot arbiter between the IF stream and the MUL microcode sequencer.
// Parks the instruction behind a MUL, drains, runs micro-ops, restores flags and replays the parked instruction.
module ucode_issue_arbiter #(
  parameter int          DRAIN_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] NOP_INSTR      = {5'b11001, 27'b0}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  input  logic        id_is_mul,
  input  logic [31:0] uc_instr,
  input  logic        uc_mux,
  input  logic        uc_release,
  input  logic [3:0]  uc_flags,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        pc_stall,
  output logic        uc_start,
  output logic        flags_restore,
  output logic [3:0]  flags_out,
  output logic        busy,
  output logic        timeout_err,
  output logic        protocol_err,
  output logic [15:0] mul_count
);

  typedef enum logic [2:0] {IDLE, DRAIN, START, UCODE, RESUME} state_t;

  state_t      state_reg;
  logic [31:0] hold_instr_reg;
  logic        hold_valid_reg;
  logic [3:0]  drain_cnt_reg;
  logic [15:0] wd_cnt_reg;
  logic [15:0] mul_count_reg;
  logic        timeout_err_reg;
  logic        protocol_err_reg;
  logic        wd_expired;

  assign wd_expired = (wd_cnt_reg == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      hold_instr_reg   <= '0;
      hold_valid_reg   <= 1'b0;
      drain_cnt_reg    <= '0;
      wd_cnt_reg       <= '0;
      mul_count_reg    <= '0;
      timeout_err_reg  <= 1'b0;
      protocol_err_reg <= 1'b0;
    end else begin
      if (id_is_mul && state_reg != IDLE)
        protocol_err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (id_is_mul) begin
            hold_instr_reg <= if_instr;
            hold_valid_reg <= if_valid;
            // The counter is preloaded one short so DRAIN lasts exactly DRAIN_CYCLES cycles.
            if (DRAIN_CYCLES == 0) begin
              state_reg <= START;
            end else begin
              drain_cnt_reg <= 4'(DRAIN_CYCLES - 1);
              state_reg     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == 4'd0)
            state_reg <= START;
          else
            drain_cnt_reg <= drain_cnt_reg - 4'd1;
        end
        START: begin
          if (mul_count_reg != 16'hFFFF)
            mul_count_reg <= mul_count_reg + 16'd1;
          wd_cnt_reg <= '0;
          state_reg  <= UCODE;
        end
        UCODE: begin
          wd_cnt_reg <= wd_cnt_reg + 16'd1;
          if (uc_release) begin
            state_reg <= RESUME;
          end else if (wd_expired) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= RESUME;
          end
        end
        RESUME: begin
          hold_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    id_instr      = NOP_INSTR;
    id_valid      = 1'b0;
    pc_stall      = 1'b0;
    uc_start      = 1'b0;
    flags_restore = 1'b0;
    flags_out     = 4'd0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          id_instr = if_instr;
          id_valid = if_valid;
          pc_stall = id_is_mul;
        end
        DRAIN: pc_stall = 1'b1;
        START: begin
          pc_stall = 1'b1;
          uc_start = 1'b1;
        end
        UCODE: begin
          pc_stall = 1'b1;
          if (uc_mux) begin
            id_instr = uc_instr;
            id_valid = 1'b1;
          end
          if (uc_release || wd_expired) begin
            flags_restore = 1'b1;
            flags_out     = uc_flags;
          end
        end
        RESUME: begin
          id_instr = hold_instr_reg;
          id_valid = hold_valid_reg;
        end
        default: ;
      endcase
    end
  end

  assign busy         = !rst && (state_reg != IDLE);
  assign timeout_err  = timeout_err_reg;
  assign protocol_err = protocol_err_reg;
  assign mul_count    = mul_count_reg;

endmodule
